data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Data-side memory responder for the single-cycle RV32I core. It serves the load/store port driven by the datapath (dAddr, dWdata, funct3) and returns dRdata in the same cycle.
- Holds a word-organised data RAM with byte-lane writes.
- Performs load sign/zero extension.
- Exposes a small MMIO window: GPIO output register, store counter, error status.
- Detects misaligned accesses and reports them through a sticky flag.

Parameters:
DEPTH_WORDS, 256, number of 32-bit RAM words (power of two, ≥4); RAM occupies byte addresses 0 .. DEPTH_WORDS*4-1
MMIO_BASE, 32'h1000_0000, base byte address of the MMIO window (word aligned)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
d_wr_en  input  1  store request this cycle (from control unit)
d_rd_en  input  1  load request this cycle (from control unit)
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
dAddr  input  32  byte address (ALU result)
dWdata  input  32  store data (rs2), right-aligned
dRdata  output  32  load data, extended, combinational
gpio_out  output  32  GPIO register contents
misalign_err  output  1  sticky misaligned-access flag
store_cnt  output  16  count of committed stores

Behaviour:
- Reset (rst=0, async): gpio_out=0, misalign_err=0, store_cnt=0. RAM contents are not reset.
- Decode:
  - RAM hit when dAddr < DEPTH_WORDS*4; word index = dAddr[log2(DEPTH_WORDS)+1:2].
  - GPIO register at MMIO_BASE+0 (read/write).
  - STORE_CNT at MMIO_BASE+4 (read-only; zero-extended to 32 bits on read).
  - ERR at MMIO_BASE+8: read returns {31'b0, misalign_err}; a write with bit0=1 clears the flag.
  - All other addresses: reads return 0, writes are ignored and not counted.
- Misalignment: H/HU with dAddr[0]=1, or W with dAddr[1:0]!=0, when d_rd_en or d_wr_en is high.
  - Access is suppressed: no write, no count, dRdata=0.
  - misalign_err is set at the next edge.
  - Set beats a simultaneous ERR clear.
- Loads (combinational, zero latency):
  - dRdata=0 when d_rd_en=0.
  - B/BU select byte lane dAddr[1:0], then sign-extend (B) or zero-extend (BU).
  - H/HU select half dAddr[1], then sign-extend (H) or zero-extend (HU).
  - W passes the word unchanged.
  - funct3 011/110/111 returns 0.
  - MMIO reads use the same lane/extension rules on the 32-bit register value.
- Stores (rising edge, d_wr_en=1, aligned, decoded):
  - B writes lane dAddr[1:0] with dWdata[7:0].
  - H writes lanes by dAddr[1] with dWdata[15:0].
  - W writes all four lanes.
  - Other funct3 values: no write, no count.
  - GPIO/ERR stores use the same lane masking.
- store_cnt increments by 1 per committed store (RAM or MMIO writable register). It wraps FFFF→0000.
- d_rd_en and d_wr_en both high at the same address: dRdata shows pre-write data for the whole cycle (read-before-write); the new value is visible from the next cycle.
- Reset asserted mid-cycle: the store in flight is dropped; registers clear immediately; RAM keeps its prior contents.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 → 0xDEADBEEF. LB @0x10 → 0xFFFFFFEF. LBU @0x13 → 0x000000DE. LH @0x12 → 0xFFFFDEAD. LHU @0x10 → 0x0000BEEF.
- After the above, SB 0x55 @0x11 then LW @0x10 → 0xDEAD55EF. SH 0x1234 @0x12 then LW → 0x123455EF. store_cnt = 3.
- LW @0x22 with d_rd_en → dRdata=0; misalign_err=1 next edge. SH @0x21 → RAM unchanged, store_cnt unchanged. SW 1 to MMIO_BASE+8 → misalign_err=0.
- Same-cycle misaligned access + ERR clear → misalign_err stays 1.
- SW 0xA5A5A5A5 to MMIO_BASE → gpio_out=0xA5A5A5A5 at next edge. SB 0x00 @MMIO_BASE+1 → 0xA5A500A5. SW to MMIO_BASE+4 → ignored.
- Preload store_cnt to 0xFFFF via 65535 SWs, one more SW → store_cnt=0x0000.
- Read+write 0x11111111 same cycle @0x40 (old 0x22222222) → dRdata=0x22222222; next-cycle LW → 0x11111111.
- Assert rst low mid-run → gpio_out, store_cnt, misalign_err = 0 asynchronously; previously stored RAM word still reads back.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-side memory responder for a single-cycle RV32I core: byte-lane data RAM,
// load extension, MMIO window (GPIO, store counter, error status) and a sticky misalignment flag.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_wr_en,
    input  logic        d_rd_en,
    input  logic [2:0]  funct3,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWdata,
    output logic [31:0] dRdata,
    output logic [31:0] gpio_out,
    output logic        misalign_err,
    output logic [15:0] store_cnt
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [29:0] GPIO_WA   = MMIO_BASE[31:2];
    localparam logic [29:0] CNT_WA    = MMIO_BASE[31:2] + 30'd1;
    localparam logic [29:0] ERR_WA    = MMIO_BASE[31:2] + 30'd2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] gpio_q, gpio_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    logic          ram_hit, gpio_hit, cnt_hit, err_hit;
    logic          misalign;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic          wr_ok, ram_we, gpio_we, err_we;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;

    assign idx      = dAddr[AW+1:2];
    assign ram_hit  = dAddr < RAM_BYTES;
    assign gpio_hit = dAddr[31:2] == GPIO_WA;
    assign cnt_hit  = dAddr[31:2] == CNT_WA;
    assign err_hit  = dAddr[31:2] == ERR_WA;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        misalign = 1'b0;
        if (d_rd_en || d_wr_en) begin
            case (funct3)
                F3_H, F3_HU: misalign = dAddr[0];
                F3_W:        misalign = |dAddr[1:0];
                default:     misalign = 1'b0;
            endcase
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = dWdata;
        case (funct3)
            F3_B: begin
                be        = 4'b0001 << dAddr[1:0];
                wdata_rep = {4{dWdata[7:0]}};
            end
            F3_H: begin
                be        = dAddr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{dWdata[15:0]}};
            end
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // A store in flight while reset is asserted is dropped, RAM included.
    assign wr_ok   = rst && d_wr_en && !misalign && (be != 4'b0000);
    assign ram_we  = wr_ok && ram_hit;
    assign gpio_we = wr_ok && gpio_hit;
    assign err_we  = wr_ok && err_hit;

    always_comb begin
        rd_word = 32'h0;
        if (ram_hit)       rd_word = mem[idx];
        else if (gpio_hit) rd_word = gpio_q;
        else if (cnt_hit)  rd_word = {16'h0, cnt_q};
        else if (err_hit)  rd_word = {31'h0, err_q};
    end

    assign byte_sel = rd_word[{dAddr[1:0], 3'b000} +: 8];
    assign half_sel = dAddr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        dRdata = 32'h0;
        if (d_rd_en && !misalign) begin
            case (funct3)
                F3_B:    dRdata = {{24{byte_sel[7]}}, byte_sel};
                F3_BU:   dRdata = {24'h0, byte_sel};
                F3_H:    dRdata = {{16{half_sel[15]}}, half_sel};
                F3_HU:   dRdata = {16'h0, half_sel};
                F3_W:    dRdata = rd_word;
                default: dRdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        gpio_d = gpio_q;
        if (gpio_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) gpio_d[8*b +: 8] = wdata_rep[8*b +: 8];
            end
        end
        cnt_d = cnt_q + 16'((ram_we || gpio_we || err_we) ? 1 : 0);
        // A newly detected misalignment outranks a clear arriving in the same cycle.
        if (misalign)                               err_d = 1'b1;
        else if (err_we && be[0] && wdata_rep[0])   err_d = 1'b0;
        else                                        err_d = err_q;
    end

    // NOTE: the RAM has no reset; clearing every word would cost a reset fan-out into the array and software never relies on it.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_q <= 32'h0;
            cnt_q  <= 16'h0;
            err_q  <= 1'b0;
        end else begin
            gpio_q <= gpio_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign gpio_out     = gpio_q;
    assign store_cnt    = cnt_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-level reference model predicts each cycle's
// outputs, a driver queues the predictions and a negedge monitor compares them.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] MMIO  = 32'h1000_0000;
    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        d_wr_en = 1'b0, d_rd_en = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] dAddr = 32'h0, dWdata = 32'h0;
    logic [31:0] dRdata, gpio_out;
    logic        misalign_err;
    logic [15:0] store_cnt;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MMIO)) dut (
        .clk(clk), .rst(rst), .d_wr_en(d_wr_en), .d_rd_en(d_rd_en), .funct3(funct3),
        .dAddr(dAddr), .dWdata(dWdata), .dRdata(dRdata), .gpio_out(gpio_out),
        .misalign_err(misalign_err), .store_cnt(store_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: RAM as a flat byte array, MMIO registers as plain values.
    logic [7:0]  ram_m [DEPTH*4];
    logic [31:0] gpio_m = 32'h0;
    int          cnt_m  = 0;
    bit          err_m  = 1'b0;

    typedef struct {
        bit          rd;
        logic [31:0] rdata;
        logic [31:0] gpio;
        logic [15:0] cnt;
        bit          err;
    } txn_t;
    txn_t sb[$];

    function automatic bit is_misaligned(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
        if (!(rd || wr)) return 1'b0;
        if ((f3 == H || f3 == HU) && a[0]) return 1'b1;
        if (f3 == W && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_word(logic [31:0] a);
        logic [31:0] base = {a[31:2], 2'b00};
        if (a < DEPTH * 4)
            return {ram_m[base+3], ram_m[base+2], ram_m[base+1], ram_m[base]};
        if (base == MMIO)     return gpio_m;
        if (base == MMIO + 4) return 32'(cnt_m);
        if (base == MMIO + 8) return {31'h0, err_m};
        return 32'h0;
    endfunction

    function automatic logic [31:0] model_read(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
        logic [31:0] w;
        logic [7:0]  by;
        logic [15:0] hw;
        if (!rd || is_misaligned(rd, wr, f3, a)) return 32'h0;
        w  = model_word(a);
        by = 8'(w >> (8 * a[1:0]));
        hw = 16'(w >> (16 * a[1]));
        case (f3)
            B:  return 32'($signed(by));
            BU: return {24'h0, by};
            H:  return 32'($signed(hw));
            HU: return {16'h0, hw};
            W:  return w;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_store(bit rd, bit wr, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
        int n;
        int off;
        logic [31:0] base = {a[31:2], 2'b00};
        bit mis = is_misaligned(rd, wr, f3, a);
        bit writable;
        bit clr = 1'b0;
        if (mis) err_m = 1'b1;
        if (!wr || mis) return;
        case (f3)
            B: n = 1;
            H: n = 2;
            W: n = 4;
            default: n = 0;
        endcase
        writable = (a < DEPTH * 4) || base == MMIO || base == MMIO + 8;
        if (n == 0 || !writable) return;
        off = int'(a[1:0]);
        for (int i = 0; i < n; i++) begin
            if (a < DEPTH * 4) ram_m[base + off + i] = wd[8*i +: 8];
            else if (base == MMIO) gpio_m[8*(off+i) +: 8] = wd[8*i +: 8];
            else if (off + i == 0 && wd[0]) clr = 1'b1;
        end
        if (clr) err_m = 1'b0;
        cnt_m = (cnt_m + 1) % 65536;
    endtask

    // One bus cycle: apply inputs, queue the prediction for this cycle, then advance the model past the next edge.
    task automatic drive(bit rd, bit wr, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                         bit use_want = 1'b0, logic [31:0] want = 32'h0);
        txn_t t;
        @(posedge clk);
        #1;
        d_rd_en = rd; d_wr_en = wr; funct3 = f3; dAddr = a; dWdata = wd;
        t.rd    = rd;
        t.rdata = use_want ? want : model_read(rd, wr, f3, a);
        t.gpio  = gpio_m;
        t.cnt   = 16'(cnt_m);
        t.err   = err_m;
        sb.push_back(t);
        model_store(rd, wr, f3, a, wd);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, W, 32'h0, 32'h0);
    endtask

    initial begin : monitor
        txn_t t;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                t = sb.pop_front();
                if (t.rd) check("dRdata", dRdata, t.rdata);
                check("gpio_out", gpio_out, t.gpio);
                check("store_cnt", 32'(store_cnt), 32'(t.cnt));
                check("misalign_err", 32'(misalign_err), 32'(t.err));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0, 1, 2, 3: return 32'($urandom_range(0, 255));
            4, 5:       return 32'($urandom_range(0, DEPTH * 4 - 1));
            6, 7:       return MMIO + 32'($urandom_range(0, 11));
            8:          return (MMIO + 32'($urandom_range(12, 31))) ^ 32'($urandom_range(0, 1) << 31);
            default:    return DEPTH * 4 + 32'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin : stim
        logic [2:0]  f3;
        logic [31:0] a;
        for (int i = 0; i < DEPTH * 4; i++) ram_m[i] = 8'h0;

        // Power-on reset
        repeat (2) @(posedge clk);
        #2;
        check("rst_gpio", gpio_out, 32'h0);
        check("rst_cnt", 32'(store_cnt), 32'h0);
        check("rst_err", 32'(misalign_err), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Give every RAM word a defined value, then reset so counters restart from zero.
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, W, 32'(i * 4), $urandom());
        idle();
        @(posedge clk); #1;
        d_wr_en = 1'b0; d_rd_en = 1'b0;
        rst = 1'b0;
        gpio_m = 32'h0; cnt_m = 0; err_m = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Loads with each extension
        drive(1'b0, 1'b1, W, 32'h10, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, W,  32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, B,  32'h10, 32'h0, 1'b1, 32'hFFFF_FFEF);
        drive(1'b1, 1'b0, BU, 32'h13, 32'h0, 1'b1, 32'h0000_00DE);
        drive(1'b1, 1'b0, H,  32'h12, 32'h0, 1'b1, 32'hFFFF_DEAD);
        drive(1'b1, 1'b0, HU, 32'h10, 32'h0, 1'b1, 32'h0000_BEEF);
        drive(1'b0, 1'b1, B,  32'h11, 32'h55);
        drive(1'b1, 1'b0, W,  32'h10, 32'h0, 1'b1, 32'hDEAD_55EF);
        drive(1'b0, 1'b1, H,  32'h12, 32'h1234);
        drive(1'b1, 1'b0, W,  32'h10, 32'h0, 1'b1, 32'h1234_55EF);
        check("cnt_after_3_stores", 32'(store_cnt), 32'd3);

        // Misalignment and error clear
        drive(1'b1, 1'b0, W, 32'h22, 32'h0, 1'b1, 32'h0);
        idle();
        check("err_set", 32'(misalign_err), 32'd1);
        drive(1'b0, 1'b1, H, 32'h21, 32'hBEEF);
        drive(1'b1, 1'b0, W, 32'h20, 32'h0);
        check("cnt_misaligned_store", 32'(store_cnt), 32'd3);
        drive(1'b0, 1'b1, W, MMIO + 8, 32'h1);
        idle();
        check("err_cleared", 32'(misalign_err), 32'd0);
        drive(1'b1, 1'b0, H, 32'h23, 32'h0, 1'b1, 32'h0);
        drive(1'b1, 1'b1, H, MMIO + 9, 32'h1, 1'b1, 32'h0);
        idle();
        check("err_set_beats_clear", 32'(misalign_err), 32'd1);

        // GPIO and read-only counter
        drive(1'b0, 1'b1, W, MMIO, 32'hA5A5_A5A5);
        idle();
        check("gpio_word", gpio_out, 32'hA5A5_A5A5);
        drive(1'b0, 1'b1, B, MMIO + 1, 32'h00);
        idle();
        check("gpio_byte", gpio_out, 32'hA5A5_00A5);
        drive(1'b0, 1'b1, W, MMIO + 4, 32'hFFFF);
        idle();
        check("cnt_ro_ignored", 32'(store_cnt), 32'd6);

        // Read-before-write at the same address
        drive(1'b0, 1'b1, W, 32'h40, 32'h2222_2222);
        drive(1'b1, 1'b1, W, 32'h40, 32'h1111_1111, 1'b1, 32'h2222_2222);
        drive(1'b1, 1'b0, W, 32'h40, 32'h0, 1'b1, 32'h1111_1111);

        // Counter wrap
        while (cnt_m != 16'hFFFF)
            drive(1'b0, 1'b1, W, 32'($urandom_range(0, DEPTH - 1) * 4), $urandom());
        idle();
        check("cnt_full", 32'(store_cnt), 32'h0000_FFFF);
        drive(1'b0, 1'b1, W, 32'h0, $urandom());
        idle();
        check("cnt_wrap", 32'(store_cnt), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = rand_addr();
            drive(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4), f3, a, $urandom());
        end

        // Reset asserted mid-cycle with a store in flight
        drive(1'b0, 1'b1, W, 32'h80, 32'h5A5A_1234);
        drive(1'b0, 1'b1, W, MMIO, 32'h0F0F_0F0F);
        drive(1'b1, 1'b0, H, 32'h81, 32'h0);
        @(posedge clk); #1;
        d_rd_en = 1'b0; d_wr_en = 1'b1; funct3 = W; dAddr = 32'h80; dWdata = 32'hFFFF_FFFF;
        #2;
        rst = 1'b0;
        gpio_m = 32'h0; cnt_m = 0; err_m = 1'b0;
        #1;
        check("async_rst_gpio", gpio_out, 32'h0);
        check("async_rst_cnt", 32'(store_cnt), 32'h0);
        check("async_rst_err", 32'(misalign_err), 32'h0);
        @(posedge clk); #1;
        d_wr_en = 1'b0;
        rst = 1'b1;
        drive(1'b1, 1'b0, W, 32'h80, 32'h0, 1'b1, 32'h5A5A_1234);
        idle();
        idle();
        @(negedge clk); #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
